// File: rtl/hub75_uart_frame_rx.sv
// UART byte receiver and R/G/B frame parser feeding the HUB75 framebuffer.
// A 0xA5 sync byte starts a frame of WIDTH*HEIGHT pixels sent as R,G,B.
module hub75_uart_frame_rx #(
   parameter int CLK_HZ = 16000000,
   parameter int BAUD   = 1000000,
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 32,
   parameter int AW     = 11
) (
   input  logic          pin_clk,
   input  logic          rst,
   input  logic          pin_rx,
   output logic          fb_we,
   output logic [AW-1:0] fb_addr,
   output logic [23:0]   fb_rgb,
   output logic          frame_done,
   output logic          frame_err,
   output logic [7:0]    rx_byte,
   output logic          rx_valid
);

   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [AW-1:0] X_LAST = AW'(WIDTH - 1);
   localparam logic [AW-1:0] Y_LAST = AW'(HEIGHT - 1);
   localparam logic [AW-1:0] W_AW   = AW'(WIDTH);
   localparam logic [AW-1:0] AW_ONE = AW'(1);

   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [1:0] {
      U_IDLE,
      U_START,
      U_DATA,
      U_STOP
   } ustate_t;

   typedef enum logic [1:0] {
      P_HUNT,
      P_R,
      P_G,
      P_B
   } pstate_t;

   logic rx_s1;
   logic rx_s2;

   ustate_t ust;
   ustate_t ust_nx;

   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          hold;

   logic tick_half;
   logic tick_bit;
   logic start_go;
   logic cnt_clr;
   logic bit_smp;
   logic stop_ok;
   logic stop_bad;

   pstate_t pst;
   pstate_t pst_nx;

   logic [AW-1:0] x;
   logic [AW-1:0] y;
   logic [7:0]    r_q;
   logic [7:0]    g_q;

   logic sync_hit;
   logic r_ld;
   logic g_ld;
   logic px_wr;
   logic last_px;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge pin_clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= pin_rx;
         rx_s2 <= rx_s1;
      end
   end

   assign tick_half = (cnt == CNT_HALF);
   assign tick_bit  = (cnt == CNT_LAST);

   always_ff @(posedge pin_clk) begin
      if (rst) begin
         ust <= U_IDLE;
      end else begin
         ust <= ust_nx;
      end
   end

   always_comb begin
      ust_nx = ust;
      unique case (ust)
         U_IDLE: begin
            if (!rx_s2 && !hold) begin
               ust_nx = U_START;
            end
         end
         U_START: begin
            if (tick_half) begin
               ust_nx = rx_s2 ? U_IDLE : U_DATA;
            end
         end
         U_DATA: begin
            if (tick_bit && (bit_cnt == 3'd7)) begin
               ust_nx = U_STOP;
            end
         end
         U_STOP: begin
            if (tick_bit) begin
               ust_nx = U_IDLE;
            end
         end
         default: ust_nx = U_IDLE;
      endcase
   end

   always_comb begin
      start_go = 1'b0;
      cnt_clr  = 1'b0;
      bit_smp  = 1'b0;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      unique case (ust)
         U_IDLE: begin
            start_go = !rx_s2 && !hold;
            cnt_clr  = 1'b1;
         end
         U_START: begin
            cnt_clr = tick_half;
         end
         U_DATA: begin
            cnt_clr = tick_bit;
            bit_smp = tick_bit;
         end
         U_STOP: begin
            cnt_clr  = tick_bit;
            stop_ok  = tick_bit && rx_s2;
            stop_bad = tick_bit && !rx_s2;
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   // The detection cycle in IDLE counts as the first half-bit cycle.
   always_ff @(posedge pin_clk) begin
      if (rst) begin
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         hold      <= 1'b0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= stop_ok;
         frame_err <= stop_bad;
         if (start_go) begin
            cnt     <= CNT_ONE;
            bit_cnt <= '0;
         end else if (cnt_clr) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
         if (bit_smp) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (stop_ok) begin
            rx_byte <= shreg;
         end
         if (stop_bad) begin
            hold <= 1'b1;
         end else if (rx_s2) begin
            hold <= 1'b0;
         end
      end
   end

   assign last_px = (x == X_LAST) && (y == Y_LAST);

   always_ff @(posedge pin_clk) begin
      if (rst) begin
         pst <= P_HUNT;
      end else begin
         pst <= pst_nx;
      end
   end

   always_comb begin
      pst_nx = pst;
      if (frame_err) begin
         pst_nx = P_HUNT;
      end else if (rx_valid) begin
         unique case (pst)
            P_HUNT: begin
               if (rx_byte == SYNC) begin
                  pst_nx = P_R;
               end
            end
            P_R: pst_nx = P_G;
            P_G: pst_nx = P_B;
            P_B: pst_nx = last_px ? P_HUNT : P_R;
            default: pst_nx = P_HUNT;
         endcase
      end
   end

   always_comb begin
      sync_hit = 1'b0;
      r_ld     = 1'b0;
      g_ld     = 1'b0;
      px_wr    = 1'b0;
      if (rx_valid && !frame_err) begin
         unique case (pst)
            P_HUNT: sync_hit = (rx_byte == SYNC);
            P_R:    r_ld = 1'b1;
            P_G:    g_ld = 1'b1;
            P_B:    px_wr = 1'b1;
            default: sync_hit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge pin_clk) begin
      if (rst) begin
         x          <= '0;
         y          <= '0;
         r_q        <= '0;
         g_q        <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_rgb     <= '0;
         frame_done <= 1'b0;
      end else begin
         fb_we      <= px_wr;
         frame_done <= px_wr && last_px;
         if (r_ld) begin
            r_q <= rx_byte;
         end
         if (g_ld) begin
            g_q <= rx_byte;
         end
         if (px_wr) begin
            fb_addr <= y * W_AW + x;
            fb_rgb  <= {r_q, g_q, rx_byte};
         end
         if (sync_hit) begin
            x <= '0;
            y <= '0;
         end else if (px_wr) begin
            if (x == X_LAST) begin
               x <= '0;
               y <= last_px ? '0 : y + AW_ONE;
            end else begin
               x <= x + AW_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_hub75_uart_frame_rx.sv
// Bench for hub75_uart_frame_rx: directed and randomized byte streams
// compared against a byte-position frame model.
`timescale 1ns/1ps
module tb_hub75_uart_frame_rx;

   localparam int AW     = 3;
   localparam int W      = 4;
   localparam int H      = 2;
   localparam int NPIX   = W * H;
   localparam int BIT_NS = 160;

   typedef struct packed {
      logic          done;
      logic [AW-1:0] addr;
      logic [23:0]   rgb;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pin_rx = 1'b1;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_rgb;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    rx_byte;
   logic          rx_valid;

   always #5 clk = ~clk;

   hub75_uart_frame_rx #(
      .CLK_HZ (16000000),
      .BAUD   (1000000),
      .WIDTH  (W),
      .HEIGHT (H),
      .AW     (AW)
   ) dut (
      .pin_clk    (clk),
      .rst        (rst),
      .pin_rx     (pin_rx),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_rgb     (fb_rgb),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid)
   );

   wr_t        wr_act[$];
   wr_t        wr_exp[$];
   logic [7:0] rx_act[$];
   logic [7:0] rx_exp[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_err_act = 0;
   int n_b2b = 0;
   int n_lag = 0;
   int n_lone = 0;
   logic p_we = 1'b0;
   logic p_done = 1'b0;
   logic p_err = 1'b0;
   logic p_rv = 1'b0;

   int rx_rd = 0;
   int wr_rd = 0;
   int err_base = 0;
   int n_err_exp = 0;

   int         mpos = -1;
   logic [7:0] mbuf[3];

   always @(negedge clk) begin
      if (rx_valid) rx_act.push_back(rx_byte);
      if (fb_we) wr_act.push_back(wr_t'{frame_done, fb_addr, fb_rgb});
      if (frame_err) n_err_act <= n_err_act + 1;
      if (frame_done && !fb_we) n_lone <= n_lone + 1;
      if (fb_we && !p_rv) n_lag <= n_lag + 1;
      if ((fb_we && p_we) || (rx_valid && p_rv) ||
          (frame_err && p_err) || (frame_done && p_done))
         n_b2b <= n_b2b + 1;
      p_we   <= fb_we;
      p_done <= frame_done;
      p_err  <= frame_err;
      p_rv   <= rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame model: byte position within the frame decides everything.
   task automatic mdl_byte(input logic [7:0] b);
      int px;
      if (mpos < 0) begin
         if (b == 8'hA5) mpos = 0;
      end else begin
         mbuf[mpos % 3] = b;
         if (mpos % 3 == 2) begin
            px = mpos / 3;
            wr_exp.push_back(wr_t'{px == NPIX - 1, AW'(px),
                                   {mbuf[0], mbuf[1], b}});
         end
         mpos++;
         if (mpos == 3 * NPIX) mpos = -1;
      end
   endtask

   task automatic tx_raw(input logic [7:0] b, input bit stop,
                         input int bn);
      pin_rx = 1'b0;
      #bn;
      for (int i = 0; i < 8; i++) begin
         pin_rx = b[i];
         #bn;
      end
      pin_rx = stop;
      #bn;
      pin_rx = 1'b1;
      #(bn + 20);
   endtask

   task automatic send(input logic [7:0] b, input bit stop = 1'b1,
                       input int bn = BIT_NS);
      tx_raw(b, stop, bn);
      if (stop) begin
         rx_exp.push_back(b);
         mdl_byte(b);
      end else begin
         n_err_exp++;
         mpos = -1;
      end
   endtask

   task automatic send_px(input logic [23:0] p, input int bn = BIT_NS);
      send(p[23:16], 1'b1, bn);
      send(p[15:8], 1'b1, bn);
      send(p[7:0], 1'b1, bn);
   endtask

   task automatic check_phase(input string tag);
      int na;
      repeat (10) @(negedge clk);
      na = rx_act.size() - rx_rd;
      chk({tag, ":rx_n"}, 32'(na), 32'(rx_exp.size()));
      for (int i = 0; i < rx_exp.size(); i++)
         if (rx_rd + i < rx_act.size())
            chk({tag, ":rx"}, 32'(rx_act[rx_rd + i]), 32'(rx_exp[i]));
      rx_rd = rx_act.size();
      rx_exp.delete();
      na = wr_act.size() - wr_rd;
      chk({tag, ":wr_n"}, 32'(na), 32'(wr_exp.size()));
      for (int i = 0; i < wr_exp.size(); i++)
         if (wr_rd + i < wr_act.size()) begin
            chk({tag, ":addr"}, 32'(wr_act[wr_rd + i].addr),
                32'(wr_exp[i].addr));
            chk({tag, ":rgb"}, 32'(wr_act[wr_rd + i].rgb),
                32'(wr_exp[i].rgb));
            chk({tag, ":done"}, 32'(wr_act[wr_rd + i].done),
                32'(wr_exp[i].done));
         end
      wr_rd = wr_act.size();
      wr_exp.delete();
      chk({tag, ":err_n"}, 32'(n_err_act - err_base), 32'(n_err_exp));
      err_base = n_err_act;
      n_err_exp = 0;
      chk({tag, ":b2b"}, 32'(n_b2b), 32'd0);
      chk({tag, ":we_lag"}, 32'(n_lag), 32'd0);
      chk({tag, ":lone_done"}, 32'(n_lone), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ":we"}, 32'(fb_we), 32'd0);
      chk({tag, ":addr"}, 32'(fb_addr), 32'd0);
      chk({tag, ":rgb"}, 32'(fb_rgb), 32'd0);
      chk({tag, ":done"}, 32'(frame_done), 32'd0);
      chk({tag, ":err"}, 32'(frame_err), 32'd0);
      chk({tag, ":byte"}, 32'(rx_byte), 32'd0);
      chk({tag, ":valid"}, 32'(rx_valid), 32'd0);
   endtask

   initial begin
      logic [23:0] px;
      int          nj;
      int          bn;
      rst = 1'b1;
      pin_rx = 1'b1;
      repeat (4) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send(8'h5A);
      check_phase("single");
      chk("single:hold", 32'(rx_byte), 32'h5A);

      @(negedge clk);
      pin_rx = 1'b0;
      repeat (4) @(negedge clk);
      pin_rx = 1'b1;
      repeat (40) @(negedge clk);
      send(8'h33);
      check_phase("glitch");

      send(8'h00);
      send(8'hA5);
      for (int n = 0; n < NPIX; n++)
         send_px({8'(n), 8'(n + 16), 8'(n + 32)});
      check_phase("frame");
      chk("frame:addr_hold", 32'(fb_addr), 32'd7);
      chk("frame:rgb_hold", 32'(fb_rgb), 32'h071727);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      check_phase("hunt");

      send(8'hA5);
      send_px(24'hA5A5A5);
      send_px(24'($urandom));
      check_phase("a5data");
      for (int n = 2; n < NPIX; n++) send_px(24'($urandom));
      check_phase("a5end");

      send(8'hA5);
      send_px(24'($urandom));
      send_px(24'($urandom));
      send(8'($urandom), 1'b0);
      check_phase("ferr");
      send(8'hA5);
      for (int n = 0; n < NPIX; n++) send_px(24'($urandom));
      check_phase("ferr_re");

      send(8'hA5);
      send_px(24'($urandom));
      send_px(24'($urandom));
      send(8'($urandom));
      check_phase("rst_pre");
      fork
         tx_raw(8'h96, 1'b1, BIT_NS);
         begin
            #(BIT_NS * 4);
            @(negedge clk);
            rst = 1'b1;
         end
      join
      @(negedge clk);
      chk_zero("midrst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mpos = -1;
      repeat (4) @(negedge clk);
      chk_zero("postrst");
      check_phase("rst_drop");
      send(8'hA5);
      for (int n = 0; n < NPIX; n++) send_px(24'($urandom));
      check_phase("rst_frame");

      for (int f = 0; f < 4; f++) begin
         nj = $urandom_range(0, 3);
         for (int j = 0; j < nj; j++)
            send(8'($urandom), 1'b1, $urandom_range(155, 165));
         send(8'hA5, 1'b1, $urandom_range(155, 165));
         for (int n = 0; n < NPIX; n++) begin
            if (f == 2 && n == 5) begin
               send(8'($urandom), 1'b0);
               send(8'hA5);
            end
            px = 24'($urandom);
            bn = $urandom_range(155, 165);
            send_px(px, bn);
         end
         check_phase("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
